// File: rtl/stim_pkg.sv
// Shared types, default LFSR constants and the LFSR step used by stim_source.
package stim_pkg;

    // Burst sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Widest LFSR the step function handles; narrower registers are zero-extended.
    localparam int unsigned LFSR_MAX_W = 32;

    // Maximal-length Galois feedback masks and nonzero load values per supported width.
    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [3:0]  SEED_4  = 4'h1;
    localparam logic [5:0]  TAPS_6  = 6'h30;
    localparam logic [5:0]  SEED_6  = 6'h01;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [7:0]  SEED_8  = 8'h01;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [15:0] SEED_16 = 16'h0001;

    // One Galois right-shift step: fold the tap mask in when a one falls off the bottom.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        logic [LFSR_MAX_W-1:0] shifted;
        shifted = state >> 1;
        return state[0] ? (shifted ^ taps) : shifted;
    endfunction

endpackage

// File: rtl/stim_source_exp_fifo.sv
// Expected-value FIFO: synchronous, power-of-two depth, head visible with zero latency.
module exp_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    // Guard both ports so a stray push when full or pop when empty cannot corrupt pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (occ == OW'(DEPTH));
    assign empty = (occ == '0);
    assign head  = mem[rd_ptr];

    // Pointers and occupancy; reset discards contents by clearing these only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage array; no reset needed since occupancy gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/stim_source.sv
// LFSR stimulus driver with an expected-value queue for pass-through DUT checking.
module stim_source
    import stim_pkg::*;
#(
    parameter int unsigned        D_WIDTH   = 6,
    parameter int unsigned        DEPTH     = 8,
    parameter int unsigned        BURST_LEN = 16,
    parameter logic [D_WIDTH-1:0] SEED      = D_WIDTH'(SEED_6),
    parameter logic [D_WIDTH-1:0] TAPS      = D_WIDTH'(TAPS_6),
    parameter logic [D_WIDTH-1:0] XOR_MASK  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] stim_data,
    output logic               stim_valid,
    input  logic               stim_ready,
    input  logic               rtl_valid,
    output logic [D_WIDTH-1:0] model_data_a,
    output logic [D_WIDTH-1:0] model_data_b,
    output logic               model_valid,
    output logic               underflow_err
);

    localparam int unsigned        CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t             state;
    logic [D_WIDTH-1:0] lfsr;
    logic [D_WIDTH-1:0] lfsr_nxt;
    logic [CNT_W-1:0]   count;
    logic [D_WIDTH-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               underflow_hit;

    // Offer a word only while sending and there is room to remember it.
    assign stim_valid    = (state == RUN) && !fifo_full;
    assign push          = stim_valid && stim_ready;
    assign pop           = rtl_valid && !fifo_empty;
    assign underflow_hit = rtl_valid && fifo_empty;

    assign stim_data    = lfsr;
    assign model_data_a = head ^ XOR_MASK;
    assign model_valid  = !fifo_empty;

    assign lfsr_nxt = D_WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAPS)));

    // Every accepted word is what the DUT must later return (after the mask).
    exp_fifo #(
        .WIDTH (D_WIDTH),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (lfsr),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Burst sequencer: owns lfsr, word count, busy/done and the sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lfsr          <= SEED;
            count         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        lfsr          <= SEED;
                        count         <= '0;
                        underflow_err <= 1'b0;
                    end
                end
                RUN: begin
                    // lfsr holds while stalled so stim_data is stable until accepted.
                    if (push) begin
                        lfsr  <= lfsr_nxt;
                        count <= count + CNT_W'(1);
                        if (count == LAST_CNT) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // An underflow in the same cycle as a start still wins over the clear.
            if (underflow_hit) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Remember the expected value of the DUT word just consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_data_b <= '0;
        end else if (pop) begin
            model_data_b <= head ^ XOR_MASK;
        end
    end

endmodule

// File: tb/tb_stim_source.sv
// Scoreboard bench for stim_source: reference model of bursts and queue, checked every cycle.
`timescale 1ns/1ps
module tb_stim_source;

    localparam int        DEPTH     = 8;
    localparam int        BURST_LEN = 16;
    localparam logic [5:0] SEED     = 6'h01;
    localparam logic [5:0] TAPS     = 6'h30;
    localparam logic [5:0] XOR_MASK = 6'h3F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stim_ready = 1'b0;
    logic       rtl_valid = 1'b0;
    logic       busy;
    logic       done;
    logic       stim_valid;
    logic       model_valid;
    logic       underflow_err;
    logic [5:0] stim_data;
    logic [5:0] model_data_a;
    logic [5:0] model_data_b;

    always #5 clk = ~clk;

    stim_source #(
        .D_WIDTH   (6),
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN),
        .SEED      (SEED),
        .TAPS      (TAPS),
        .XOR_MASK  (XOR_MASK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .stim_data     (stim_data),
        .stim_valid    (stim_valid),
        .stim_ready    (stim_ready),
        .rtl_valid     (rtl_valid),
        .model_data_a  (model_data_a),
        .model_data_b  (model_data_b),
        .model_valid   (model_valid),
        .underflow_err (underflow_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 sending, 2 waiting for queue to empty, 3 done pulse
    logic [5:0] m_q[$];
    logic [5:0] m_lfsr = SEED;
    logic [5:0] m_b = 6'h00;
    int         m_sent = 0;
    int         m_mode = 0;
    bit         m_uf = 1'b0;
    int         m_sz;
    bit         m_offer;
    bit         m_uf_hit;

    function automatic logic [5:0] ref_step(input logic [5:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 6'h00);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_lfsr = SEED;
            m_b    = 6'h00;
            m_sent = 0;
            m_mode = 0;
            m_uf   = 1'b0;
        end else begin
            m_sz     = m_q.size();
            m_offer  = (m_mode == 1) && (m_sz < DEPTH);
            m_uf_hit = rtl_valid && (m_sz == 0);
            if (rtl_valid && m_sz > 0) m_b = m_q.pop_front() ^ XOR_MASK;
            case (m_mode)
                0: if (start) begin
                    m_mode = 1;
                    m_lfsr = SEED;
                    m_sent = 0;
                    m_uf   = 1'b0;
                end
                1: if (m_offer && stim_ready) begin
                    m_q.push_back(m_lfsr);
                    m_lfsr = ref_step(m_lfsr);
                    m_sent++;
                    if (m_sent == BURST_LEN) m_mode = 2;
                end
                2: if (m_sz == 0) m_mode = 3;
                default: m_mode = 0;
            endcase
            if (m_uf_hit) m_uf = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         done_cnt = 0;
    int         last_acc = 0;
    bit         chk_en = 1'b0;
    bit         lb_mode = 1'b0;
    bit         seq_mode = 1'b0;
    int         seq_idx = 0;
    logic [5:0] seq_tbl [8];
    logic [5:0] lb_q[$];
    logic [5:0] lb_word;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            check("stim_valid", 32'(stim_valid), 32'((m_mode == 1) && (m_q.size() < DEPTH)));
            check("stim_data", 32'(stim_data), 32'(m_lfsr));
            check("busy", 32'(busy), 32'((m_mode == 1) || (m_mode == 2)));
            check("done", 32'(done), 32'(m_mode == 3));
            check("model_valid", 32'(model_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) check("model_data_a", 32'(model_data_a), 32'(m_q[0] ^ XOR_MASK));
            check("model_data_b", 32'(model_data_b), 32'(m_b));
            check("underflow_err", 32'(underflow_err), 32'(m_uf));
            if (lb_mode && rtl_valid) begin
                if (lb_q.size() == 0) begin
                    check("loopback_pending", 32'(0), 32'(1));
                end else begin
                    lb_word = lb_q.pop_front();
                    check("loopback_a", 32'(model_data_a), 32'(lb_word ^ XOR_MASK));
                end
            end
            if (stim_valid && stim_ready) begin
                if (lb_mode) begin
                    lb_q.push_back(stim_data);
                    last_acc = cyc + 1;
                end
                if (seq_mode && seq_idx < 8) check("seq_word", 32'(stim_data), 32'(seq_tbl[seq_idx]));
                seq_idx++;
            end
            if (done) begin
                done_cnt++;
                if (lb_mode) check("done_latency", 32'(cyc - last_acc), 32'(2));
            end
        end
    end

    // ---------------- drivers ----------------
    bit rnd_ready = 1'b0;
    bit rnd_rv = 1'b0;
    bit rnd_start = 1'b0;
    bit hs_pre = 1'b0;

    // Advance one clock; inputs change 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        hs_pre = stim_valid && stim_ready;
        @(posedge clk);
        #1;
        if (lb_mode) rtl_valid = hs_pre;
        else if (rnd_rv) rtl_valid = ($urandom_range(0, 2) == 0);
        if (rnd_ready) stim_ready = ($urandom_range(0, 3) != 0);
        if (rnd_start) start = ($urandom_range(0, 15) == 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int  d0;
        bit  got;
        d0  = done_cnt;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            if (done_cnt != d0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no done pulse within %0d cycles", name, bound);
        end
    endtask

    task automatic wait_sent(input int n, input string name);
        for (int i = 0; i < 100 && m_sent < n; i++) tick();
        check(name, 32'(m_sent), 32'(n));
    endtask

    initial begin
        int d0;
        seq_tbl[0] = 6'h01; seq_tbl[1] = 6'h30; seq_tbl[2] = 6'h18; seq_tbl[3] = 6'h0C;
        seq_tbl[4] = 6'h06; seq_tbl[5] = 6'h03; seq_tbl[6] = 6'h31; seq_tbl[7] = 6'h28;

        // Reset
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        tick();
        check("rst_stim_data", 32'(stim_data), 32'(6'h01));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_model_valid", 32'(model_valid), 32'(0));
        rst_n = 1'b1;
        tick();

        // Sequence with no pops: eight words then stall on full
        stim_ready = 1'b1;
        seq_mode   = 1'b1;
        seq_idx    = 0;
        pulse_start();
        repeat (12) tick();
        check("seq_full_stall", 32'(stim_valid), 32'(0));
        check("seq_accepts", 32'(seq_idx), 32'(8));
        check("seq_full_busy", 32'(busy), 32'(1));
        seq_mode = 1'b0;
        rnd_rv   = 1'b1;
        wait_done(300, "seq_done");
        rnd_rv    = 1'b0;
        rtl_valid = 1'b0;
        tick();

        // Underflow on an empty queue, sticky until the next start
        rtl_valid = 1'b1;
        tick();
        rtl_valid = 1'b0;
        check("uf_set", 32'(underflow_err), 32'(1));
        repeat (3) tick();
        check("uf_sticky", 32'(underflow_err), 32'(1));

        // Back-pressure on word 3
        stim_ready = 1'b1;
        pulse_start();
        check("uf_cleared", 32'(underflow_err), 32'(0));
        wait_sent(3, "bp_reach");
        stim_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", 32'(stim_data), 32'(6'h0C));
            check("bp_valid", 32'(stim_valid), 32'(1));
        end
        stim_ready = 1'b1;
        tick();
        check("bp_resume", 32'(stim_data), 32'(6'h06));
        rnd_rv = 1'b1;
        wait_done(300, "bp_done");
        rnd_rv    = 1'b0;
        rtl_valid = 1'b0;
        tick();

        // Loopback bursts with random ready
        lb_q.delete();
        lb_mode   = 1'b1;
        rnd_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            d0 = done_cnt;
            pulse_start();
            wait_done(400, "lb_done");
            repeat (3) tick();
            check("lb_one_done", 32'(done_cnt - d0), 32'(1));
            check("lb_no_uf", 32'(underflow_err), 32'(0));
        end
        lb_mode    = 1'b0;
        rnd_ready  = 1'b0;
        rtl_valid  = 1'b0;
        stim_ready = 1'b1;
        check("lb_drained", 32'(lb_q.size()), 32'(0));
        tick();

        // Asynchronous reset mid-burst
        pulse_start();
        wait_sent(5, "rst_reach");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_model_valid", 32'(model_valid), 32'(0));
        check("mid_rst_stim_data", 32'(stim_data), 32'(6'h01));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        seq_mode = 1'b1;
        seq_idx  = 0;
        pulse_start();
        repeat (6) tick();
        seq_mode = 1'b0;
        rnd_rv   = 1'b1;
        wait_done(300, "restart_done");

        // Random mix: starts, ready and pops all random
        rnd_ready = 1'b1;
        rnd_start = 1'b1;
        repeat (800) tick();
        rnd_ready  = 1'b0;
        rnd_start  = 1'b0;
        rnd_rv     = 1'b0;
        start      = 1'b0;
        rtl_valid  = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stim_source.md
Name: stim_source

Overview:
- Stimulus and reference-model source for pass-through scenario benches.
- Drives a DUT input stream using a valid/ready handshake, with LFSR-generated data.
- Keeps every accepted word in an expected-value queue.
- Presents model_data_a and model_data_b, aligned to the DUT output valid, so a downstream checker can compare them against rtl_data.

Parameters:
- D_WIDTH, 6, data width of stimulus, DUT output and model values.
- DEPTH, 8, expected-queue depth; power of two, >= 2.
- BURST_LEN, 16, words sent per start; range 1..2^16-1.
- SEED, 6'h01, LFSR load value; must be nonzero.
- TAPS, 6'h30, Galois LFSR feedback mask. Default is x^6+x^5+1, maximal with period 63.
- XOR_MASK, 6'h00, transform the DUT is expected to apply; model value = stored word ^ XOR_MASK.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin a burst; ignored unless the FSM is in IDLE.
- busy, output, 1, high in RUN or DRAIN.
- done, output, 1, one-cycle pulse when a burst is fully drained.
- stim_data, output, D_WIDTH, stimulus word to the DUT.
- stim_valid, output, 1, stim_data valid.
- stim_ready, input, 1, DUT accepts the word.
- rtl_valid, input, 1, DUT output valid; pops the expected queue.
- model_data_a, output, D_WIDTH, expected value for the current DUT output (queue head ^ XOR_MASK).
- model_data_b, output, D_WIDTH, expected value of the previous DUT output (last popped).
- model_valid, output, 1, queue not empty.
- underflow_err, output, 1, sticky: rtl_valid arrived while the queue was empty.

Behaviour:
- Reset values: FSM=IDLE; lfsr=SEED; count=0; queue empty; all outputs 0, except stim_data=SEED (it always shows the lfsr register).
- States:
  - IDLE: start -> RUN; load lfsr=SEED, count=0, clear underflow_err.
  - RUN: stim_valid = !full. On handshake (stim_valid && stim_ready), in the same edge: push lfsr into the queue, advance the lfsr, count++. When the handshake that makes count==BURST_LEN occurs -> DRAIN.
  - DRAIN: stim_valid=0; when the queue is empty (registered) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- LFSR advance: next = lsb ? (lfsr>>1) ^ TAPS : lfsr>>1. The lfsr holds its value while stim_valid && !stim_ready, so stim_data stays stable until accepted.
- Queue rules:
  - Synchronous FIFO; push and pop may occur in the same cycle when non-empty, leaving occupancy unchanged.
  - model_data_a is combinational from the head with zero latency, so the checker samples it in the same cycle as rtl_valid.
- Pop rules:
  - A pop on rtl_valid && !empty registers head^XOR_MASK into model_data_b; model_data_b updates on the next edge.
  - rtl_valid while empty: set underflow_err; no pop; model_data_b unchanged.
  - A word pushed in the same cycle is not bypassed to the pop, so push and rtl_valid into an empty queue still sets underflow_err.
- Full: stim_valid deasserts, so overflow is impossible by construction; stim_ready is ignored while stim_valid=0.
- rtl_valid outside RUN/DRAIN: still pops if non-empty; otherwise sets underflow_err.
- start while busy: ignored; the burst in progress is unaffected.
- Reset mid-burst: asynchronous return to reset values; queue pointers clear and contents are discarded.
- Counter width: $clog2(BURST_LEN+1).

Decomposition:
- stim_pkg holds:
  - the state_t enum {IDLE, RUN, DRAIN, DONE};
  - default TAPS/SEED constants per supported width (6: 6'h30/6'h01);
  - a function lfsr_next(state, taps).
- One sub-module, exp_fifo: a parameterised synchronous FIFO with width D_WIDTH, depth DEPTH, full/empty flags and combinational head output.

Test Plan:
- Sequence: SEED=01, stim_ready=1, rtl_valid never -> stim_data accepted sequence 01,30,18,0C,06,03,31,...; stim_valid drops after 8 words (full).
- Loopback: rtl_valid = stim_valid&&stim_ready delayed 1 cycle, BURST_LEN=16 -> model_data_a equals the delayed stim_data every rtl_valid cycle. done pulses exactly once, 2 cycles after the last accept; underflow_err=0.
- Back-pressure: stim_ready low for 5 cycles on word 3 (0C) -> stim_data held at 0C, count unchanged, lfsr not advanced.
- Underflow: with the queue empty, assert rtl_valid -> underflow_err=1 next edge, stays 1 until the next start. model_data_b holds its previous value.
- XOR_MASK=6'h3F: first pop with head 01 -> model_data_a=3E in the rtl_valid cycle, model_data_b=3E next cycle.
- Reset mid-burst: rst_n low after 5 accepts -> busy=0, model_valid=0 immediately. The next start restarts at 01.
